key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Multi-key debouncer that consumes the divided clock produced by the divide stage (clkout -> tick_in).
//   - Samples active-low mechanical keys once per tick_in rising edge.
//   - Emits a one-clk key_pulse[x] when key_n[x] has been low for STABLE_CNT consecutive samples.
//   - Sits between the board key pins and user control logic; runs entirely on the system clk.
// PARAMETERS
//   KEY_NUM     4   number of independent keys
//   STABLE_CNT  8   consecutive equal samples required to accept a press/release (>=1)
//   CNT_WIDTH   4   sample counter width; must satisfy 2^CNT_WIDTH > STABLE_CNT
// PORTS
//   clk        in   1        system clock; all logic on rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   tick_in    in   1        sample clock from divide.clkout; asynchronous to logic, never used as a clock
//   key_n      in   KEY_NUM  raw keys, active low, asynchronous
//   key_pulse  out  KEY_NUM  1-clk pulse per accepted press, per key
//   key_state  out  KEY_NUM  debounced level, 1 = pressed
//   key_release out KEY_NUM  1-clk pulse per accepted release (only with KEY_RELEASE_PULSE_EN)
// BEHAVIOUR
//   Reset: key sync regs <= all 1; tick sync regs <= 0; every FSM <= IDLE; counters <= 0;
//     key_pulse, key_state, key_release <= 0.
//   Tick: tick_in passes through a 2-FF synchroniser plus a delay reg.
//     - tick = sync2 & ~sync3: one clk wide per tick_in rising edge.
//     - tick_in held high produces exactly one tick.
//   Keys: each key_n bit passes through a 2-FF synchroniser -> ks[x]. FSMs read ks only in tick cycles.
//     No state or counter change in non-tick cycles.
//   Per-key FSM (cnt = CNT_WIDTH bits). All transitions below occur on a tick:
//     IDLE        ks=0 -> PRESS_CHK, cnt=1.
//                 If STABLE_CNT==1: -> HELD directly, with press pulse.
//     PRESS_CHK   ks=1 -> IDLE, cnt=0.
//                 ks=0 & cnt==STABLE_CNT-1 -> HELD, cnt=0, press pulse.
//                 else cnt++.
//     HELD        ks=1 -> REL_CHK, cnt=1.
//                 If STABLE_CNT==1: -> IDLE directly, with release pulse.
//     REL_CHK     ks=0 -> HELD, cnt=0.
//                 ks=1 & cnt==STABLE_CNT-1 -> IDLE, cnt=0, release pulse.
//                 else cnt++.
//   Outputs (all registered):
//     - key_pulse[x] = 1 exactly in the cycle after the tick that enters HELD; 0 otherwise.
//     - key_state[x] = 1 while the FSM is in HELD or REL_CHK.
//     - Press accepted on the STABLE_CNT-th consecutive low sample. Any high sample before that
//       restarts qualification; no partial credit.
//   Latency: tick_in rise -> tick cycle = 2-3 clk (synchroniser).
//     Qualifying tick -> key_pulse = 1 clk.
//   Boundaries:
//     - Keys are fully independent; several bits of key_pulse may assert in the same cycle.
//     - A key changing in the same cycle as a tick is seen on a later tick (synchroniser delay);
//       never a partial update.
//     - Counter never exceeds STABLE_CNT-1; no wrap.
//     - A key held indefinitely gives exactly one key_pulse; no auto-repeat.
//     - rst_n asserted mid-operation: immediate return to reset values.
//     - A key still held when rst_n releases is re-qualified from IDLE and then pulses once.
// CONFIGURATION
//   KEY_RELEASE_PULSE_EN defined:
//     - key_release port present.
//     - Pulses 1 clk in the cycle after the tick that moves REL_CHK (or HELD when STABLE_CNT==1) -> IDLE.
//   KEY_RELEASE_PULSE_EN undefined:
//     - Port and logic absent.
//     - Release still qualified internally; key_state still falls after STABLE_CNT high samples.
// TESTING (clk period 84 ns; tick_in from divide N=3; KEY_NUM=4, STABLE_CNT=8)
//   1. rst_n=0, keys toggling, tick running -> key_pulse=0, key_state=0 throughout reset.
//   2. key_n[0] low for 20 ticks, then high for 20 ticks:
//      -> one 1-clk key_pulse[0] after the 8th low tick.
//      -> key_state[0]=1 until the 8th high tick, then 0.
//   3. key_n[1] low 5 ticks, high 1 tick, low 10 ticks:
//      -> single key_pulse[1] after the 8th low tick of the second segment.
//   4. key_n[2] low 7 ticks, then high:
//      -> no pulse; key_state[2] stays 0.
//      tick_in forced high for 100 clk -> only one sample taken.
//   5. key_n[0] and key_n[3] fall in the same clk and are held:
//      -> key_pulse=4'b1001 for exactly one clk; key_state=4'b1001.
//   6. key_n[1] held, rst_n pulsed low for 10 clk while HELD:
//      -> outputs 0 during reset; one new key_pulse[1] 8 ticks after reset release.
//      With KEY_RELEASE_PULSE_EN: releasing key_n[1] -> key_release[1] after the 8th high tick.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key debouncer sampled on synchronised tick_in edges; KEY_RELEASE_PULSE_EN adds key_release
module key_debounce #(
  parameter int KEY_NUM    = 4,
  parameter int STABLE_CNT = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] key_pulse,
  output logic [KEY_NUM-1:0] key_state
`ifdef KEY_RELEASE_PULSE_EN
  ,
  output logic [KEY_NUM-1:0] key_release
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   SINGLE   = (STABLE_CNT == 1);

  logic                 tick_s1_q, tick_s2_q, tick_s3_q;
  logic [KEY_NUM-1:0]   key_s1_q, key_s2_q;
  logic                 tick;
  logic [KEY_NUM-1:0]   ks;

  state_t               state_q [KEY_NUM];
  state_t               state_d [KEY_NUM];
  logic [CNT_WIDTH-1:0] cnt_q   [KEY_NUM];
  logic [CNT_WIDTH-1:0] cnt_d   [KEY_NUM];

  logic [KEY_NUM-1:0]   pulse_q, pulse_d;
  logic [KEY_NUM-1:0]   held_q, held_d;
`ifdef KEY_RELEASE_PULSE_EN
  logic [KEY_NUM-1:0]   release_q, release_d;
`endif

  // Bring tick_in and the raw keys into the clk domain; keys idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1_q <= 1'b0;
      tick_s2_q <= 1'b0;
      tick_s3_q <= 1'b0;
      key_s1_q  <= '1;
      key_s2_q  <= '1;
    end else begin
      tick_s1_q <= tick_in;
      tick_s2_q <= tick_s1_q;
      tick_s3_q <= tick_s2_q;
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
    end
  end

  // One clk strobe per rising edge of the synchronised tick, however long it stays high.
  assign tick = tick_s2_q & ~tick_s3_q;
  assign ks   = key_s2_q;

  // Per-key qualification: a run of STABLE_CNT equal samples flips the debounced level.
  always_comb begin
    pulse_d = '0;
    held_d  = '0;
`ifdef KEY_RELEASE_PULSE_EN
    release_d = '0;
`endif
    for (int k = 0; k < KEY_NUM; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (tick) begin
        unique case (state_q[k])
          IDLE: begin
            if (!ks[k]) begin
              if (SINGLE) begin
                state_d[k] = HELD;
                cnt_d[k]   = '0;
                pulse_d[k] = 1'b1;
              end else begin
                state_d[k] = PRESS_CHK;
                cnt_d[k]   = CNT_ONE;
              end
            end
          end
          PRESS_CHK: begin
            if (ks[k]) begin
              state_d[k] = IDLE;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
              state_d[k] = HELD;
              cnt_d[k]   = '0;
              pulse_d[k] = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
          end
          HELD: begin
            if (ks[k]) begin
              if (SINGLE) begin
                state_d[k] = IDLE;
                cnt_d[k]   = '0;
`ifdef KEY_RELEASE_PULSE_EN
                release_d[k] = 1'b1;
`endif
              end else begin
                state_d[k] = REL_CHK;
                cnt_d[k]   = CNT_ONE;
              end
            end
          end
          REL_CHK: begin
            if (!ks[k]) begin
              state_d[k] = HELD;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
              state_d[k] = IDLE;
              cnt_d[k]   = '0;
`ifdef KEY_RELEASE_PULSE_EN
              release_d[k] = 1'b1;
`endif
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
          end
          default: begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
      held_d[k] = (state_d[k] == HELD) || (state_d[k] == REL_CHK);
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KEY_NUM; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      pulse_q <= '0;
      held_q  <= '0;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= '0;
`endif
    end else begin
      for (int k = 0; k < KEY_NUM; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      pulse_q <= pulse_d;
      held_q  <= held_d;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  assign key_pulse = pulse_q;
  assign key_state = held_q;
`ifdef KEY_RELEASE_PULSE_EN
  assign key_release = release_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - table, directed and randomized checks of key_debounce against a sample-run model
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int KN = 4;
  localparam int SC = 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          tick_in = 1'b0;
  logic [KN-1:0] key_n   = '1;
  logic [KN-1:0] key_pulse;
  logic [KN-1:0] key_state;
`ifdef KEY_RELEASE_PULSE_EN
  logic [KN-1:0] key_release;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  key_debounce #(.KEY_NUM(KN), .STABLE_CNT(SC), .CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .key_n     (key_n),
    .key_pulse (key_pulse),
    .key_state (key_state)
`ifdef KEY_RELEASE_PULSE_EN
    ,
    .key_release (key_release)
`endif
  );

  always #42 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: the keys as the design sees them are the pin values from two
  // edges back; a sample is taken when tick_in was seen rising two edges back.
  // Each key keeps a debounced level and a run length of samples disagreeing with it.
  logic          tick_h [$];
  logic [KN-1:0] key_h  [$];
  logic [KN-1:0] m_level, m_pulse, m_rel;
  int            m_run  [KN];
  logic          m_pressed;
  int            pcnt   [KN];
  int            rcnt   [KN];
  int            base_p [KN];
  int            base_r [KN];

  initial begin
    for (int k = 0; k < KN; k++) begin
      pcnt[k] = 0;
      rcnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      tick_h  = '{1'b0, 1'b0, 1'b0, 1'b0};
      key_h   = '{4'hF, 4'hF, 4'hF, 4'hF};
      m_level = '0;
      m_pulse = '0;
      m_rel   = '0;
      for (int k = 0; k < KN; k++) m_run[k] = 0;
    end else begin
      tick_h.push_back(tick_in);
      key_h.push_back(key_n);
      void'(tick_h.pop_front());
      void'(key_h.pop_front());
      m_pulse = '0;
      m_rel   = '0;
      if (tick_h[1] && !tick_h[0]) begin
        for (int k = 0; k < KN; k++) begin
          m_pressed = ~key_h[1][k];
          if (m_pressed != m_level[k]) begin
            m_run[k]++;
            if (m_run[k] == SC) begin
              m_level[k] = m_pressed;
              m_run[k]   = 0;
              if (m_pressed) m_pulse[k] = 1'b1;
              else           m_rel[k]   = 1'b1;
            end
          end else begin
            m_run[k] = 0;
          end
        end
      end
    end
    #1;
    check("model_pulse", key_pulse, m_pulse);
    check("model_state", key_state, m_level);
`ifdef KEY_RELEASE_PULSE_EN
    check("model_release", key_release, m_rel);
`endif
    for (int k = 0; k < KN; k++) begin
      pcnt[k] += int'(key_pulse[k]);
`ifdef KEY_RELEASE_PULSE_EN
      rcnt[k] += int'(key_release[k]);
`endif
    end
  end

  task automatic snap();
    for (int k = 0; k < KN; k++) begin
      base_p[k] = pcnt[k];
      base_r[k] = rcnt[k];
    end
  endtask

  task automatic chk_pulses(input string name, input logic [KN-1:0] exp);
    for (int k = 0; k < KN; k++)
      check($sformatf("%s_pulses_key%0d", name, k), pcnt[k] - base_p[k], {31'd0, exp[k]});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One divide-by-3 tick_in period: high for one clk, low for two.
  task automatic do_tick();
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  typedef struct {
    logic [KN-1:0] kn;
    int            nticks;
    logic [KN-1:0] exp_pulse;
    logic [KN-1:0] exp_state;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #(84 * 60000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{4'b1110,  7, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1110,  1, 4'b0001, 4'b0001});
    tbl.push_back('{4'b1110, 12, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1111,  7, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1111,  1, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1111, 12, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1101,  5, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1111,  1, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1101,  7, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1101,  1, 4'b0010, 4'b0010});
    tbl.push_back('{4'b1101,  2, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1111,  8, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1011,  7, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1111,  8, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0110,  8, 4'b1001, 4'b1001});
    tbl.push_back('{4'b0110,  4, 4'b0000, 4'b1001});
    tbl.push_back('{4'b1111,  8, 4'b0000, 4'b0000});

    // Reset with keys and tick_in toggling: outputs must stay low.
    @(negedge clk);
    snap();
    for (int i = 0; i < 30; i++) begin
      tick_in = 1'(i % 2);
      key_n   = 4'($urandom);
      @(negedge clk);
    end
    check("reset_state", key_state, 4'b0000);
    chk_pulses("reset", 4'b0000);
    key_n   = '1;
    tick_in = 1'b0;
    rst_n   = 1'b1;
    cyc(4);

    foreach (tbl[i]) begin
      snap();
      key_n = tbl[i].kn;
      ticks(tbl[i].nticks);
      @(negedge clk);
      chk_pulses($sformatf("tbl%0d", i), tbl[i].exp_pulse);
      check($sformatf("tbl%0d_state", i), key_state, tbl[i].exp_state);
    end

    // tick_in stuck high yields a single sample: 6 + 1 low samples, no press yet.
    snap();
    key_n = 4'b1011;
    ticks(6);
    tick_in = 1'b1;
    cyc(100);
    tick_in = 1'b0;
    cyc(3);
    chk_pulses("stuck_tick", 4'b0000);
    check("stuck_tick_state", key_state, 4'b0000);
    do_tick();
    @(negedge clk);
    chk_pulses("stuck_tick_next", 4'b0100);
    check("stuck_tick_next_state", key_state, 4'b0100);
    key_n = '1;
    ticks(8);
    @(negedge clk);
    check("stuck_tick_rel_state", key_state, 4'b0000);

    // Reset while key 1 is held, then re-qualification after reset.
    snap();
    key_n = 4'b1101;
    ticks(10);
    @(negedge clk);
    chk_pulses("pre_rst", 4'b0010);
    check("pre_rst_state", key_state, 4'b0010);
    snap();
    rst_n = 1'b0;
    #1;
    check("async_rst_state", key_state, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick_in = 1'(i % 2);
      @(negedge clk);
    end
    check("in_rst_state", key_state, 4'b0000);
    chk_pulses("in_rst", 4'b0000);
    tick_in = 1'b0;
    rst_n   = 1'b1;
    cyc(3);
    ticks(7);
    @(negedge clk);
    chk_pulses("post_rst7", 4'b0000);
    check("post_rst7_state", key_state, 4'b0000);
    do_tick();
    @(negedge clk);
    chk_pulses("post_rst8", 4'b0010);
    check("post_rst8_state", key_state, 4'b0010);
    snap();
    key_n = '1;
    ticks(7);
    @(negedge clk);
    check("rel7_state", key_state, 4'b0010);
    do_tick();
    @(negedge clk);
    check("rel8_state", key_state, 4'b0000);
`ifdef KEY_RELEASE_PULSE_EN
    for (int k = 0; k < KN; k++)
      check($sformatf("rel_count_key%0d", k), rcnt[k] - base_r[k], (k == 1) ? 32'd1 : 32'd0);
`endif

    // Randomized keys, tick timing and occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      tick_in = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < KN; k++)
        if ($urandom_range(0, 59) == 0) key_n[k] = ~key_n[k];
      if (rst_n && $urandom_range(0, 699) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 3) == 0) rst_n = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
